// File: rtl/lincomb_pkg.sv
// Shared types and constants for the lincomb_sched sequencer.
package lincomb_pkg;

   // Sequencer states: one IDLE slot, two multiply steps, one result slot.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL_A = 2'd1,
      ST_MUL_B = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   // Weights of the fixed two-multiplier datapath this block replaces.
   localparam int unsigned COEF_A_DEF = 12;
   localparam int unsigned COEF_B_DEF = 5;

   // Requester identifier (two requesters).
   typedef logic req_id_t;

endpackage : lincomb_pkg

// File: rtl/shift_add_mult.sv
// Combinational W x W -> 2W unsigned multiplier built from shifted partial products.
module shift_add_mult #(
   parameter int W = 4
) (
   input  logic [W-1:0]   x_i,
   input  logic [W-1:0]   y_i,
   output logic [2*W-1:0] p_o
);

   logic [2*W-1:0] x_ext;

   assign x_ext = {{W{1'b0}}, x_i};

   // Accumulate x shifted by each set bit position of y.
   always_comb begin
      p_o = '0;
      for (int i = 0; i < W; i++) begin
         if (y_i[i]) begin
            p_o = p_o + (x_ext << i);
         end
      end
   end

endmodule : shift_add_mult

// File: rtl/lincomb_sched.sv
// Two-requester sequencer computing c = coef_a*a + coef_b*b on one shared multiplier.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. reqX_ready is combinational and only asserted in IDLE for the
// requester picked by the round-robin arbiter; out_valid is registered and,
// once high, out_valid/out_c/out_id hold until out_ready is seen high.
module lincomb_sched
   import lincomb_pkg::*;
#(
   parameter int W          = 4,
   parameter int COEF_A_RST = COEF_A_DEF,
   parameter int COEF_B_RST = COEF_B_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_we,
   input  logic [W-1:0]   cfg_coef_a,
   input  logic [W-1:0]   cfg_coef_b,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W:0]   out_c,
   output logic           out_id,
   output logic           busy,
   output state_t         dbg_state
);

   state_t         state_q;
   logic [W-1:0]   coef_a_q;
   logic [W-1:0]   coef_b_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   req_id_t        id_q;
   req_id_t        last_grant_q;
   logic [2*W-1:0] acc_q;
   logic [2*W:0]   out_c_q;
   req_id_t        out_id_q;
   logic           out_valid_q;

   logic           grant_any;
   req_id_t        grant_id;
   logic           accept;
   logic [W-1:0]   mul_x;
   logic [W-1:0]   mul_y;
   logic [2*W-1:0] mul_p;

   // Round-robin pick: on contention the requester that did not win last time.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_any = 1'b1;
         grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b0;
      end else if (req1_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b1;
      end
   end

   // Requests are only taken in IDLE and never while reset is asserted.
   assign accept     = (state_q == ST_IDLE) && grant_any && !rst;
   assign req0_ready = accept && (grant_id == 1'b0);
   assign req1_ready = accept && (grant_id == 1'b1);

   // Operand mux for the single multiplier; idle states feed zeros.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state_q)
         ST_MUL_A: begin
            mul_x = coef_a_q;
            mul_y = a_q;
         end
         ST_MUL_B: begin
            mul_x = coef_b_q;
            mul_y = b_q;
         end
         default: begin
            mul_x = '0;
            mul_y = '0;
         end
      endcase
   end

   shift_add_mult #(.W(W)) u_mult (
      .x_i (mul_x),
      .y_i (mul_y),
      .p_o (mul_p)
   );

   // Sequencer: accept, two multiply steps, then hold the result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         coef_a_q     <= W'(COEF_A_RST);
         coef_b_q     <= W'(COEF_B_RST);
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         acc_q        <= '0;
         out_c_q      <= '0;
         out_id_q     <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Coefficient writes land here so an op never sees a mid-flight change.
               if (cfg_we) begin
                  coef_a_q <= cfg_coef_a;
                  coef_b_q <= cfg_coef_b;
               end
               if (accept) begin
                  a_q          <= grant_id ? req1_a : req0_a;
                  b_q          <= grant_id ? req1_b : req0_b;
                  id_q         <= grant_id;
                  last_grant_q <= grant_id;
                  state_q      <= ST_MUL_A;
               end
            end
            ST_MUL_A: begin
               acc_q   <= mul_p;
               state_q <= ST_MUL_B;
            end
            ST_MUL_B: begin
               out_c_q     <= {1'b0, acc_q} + {1'b0, mul_p};
               out_id_q    <= id_q;
               out_valid_q <= 1'b1;
               state_q     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_c     = out_c_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule : lincomb_sched

// File: tb/tb_lincomb_sched.sv
// Directed bench for lincomb_sched with a queue-based result scoreboard.
module tb_lincomb_sched;
   import lincomb_pkg::*;

   localparam int W = 4;

   logic           clk;
   logic           rst;
   logic           cfg_we;
   logic [W-1:0]   cfg_coef_a;
   logic [W-1:0]   cfg_coef_b;
   logic           req0_valid;
   logic           req0_ready;
   logic [W-1:0]   req0_a;
   logic [W-1:0]   req0_b;
   logic           req1_valid;
   logic           req1_ready;
   logic [W-1:0]   req1_a;
   logic [W-1:0]   req1_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W:0]   out_c;
   logic           out_id;
   logic           busy;
   state_t         dbg_state;

   logic [2*W+1:0] exp_q[$];
   int             checks;
   int             errors;
   int             cyc;

   lincomb_sched #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_coef_a (cfg_coef_a),
      .cfg_coef_b (cfg_coef_b),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_c      (out_c),
      .out_id     (out_id),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something hangs beyond all local bounds.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every output transfer must match the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got id=%0d c=%0d with nothing expected", out_id, out_c);
         end else begin
            logic [2*W+1:0] e;
            e = exp_q.pop_front();
            if ({out_id, out_c} !== e) begin
               errors++;
               $display("FAIL result: got id=%0d c=%0d expected id=%0d c=%0d",
                        out_id, out_c, e[2*W+1], e[2*W:0]);
            end
         end
      end
   end

   // Drive one request, wait (bounded) for its grant, optionally push the expected result.
   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W:0] c, input bit expect_out);
      int  n;
      logic got;
      n   = 0;
      got = 1'b0;
      @(posedge clk); #1;
      if (id == 1'b0) begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end
      while (!got && n < 50) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
         n++;
      end
      chk("grant_seen", 32'(got), 32'd1);
      if (got && expect_out) exp_q.push_back({id, c});
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Bounded wait until the block is idle and all expected results were taken.
   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n0, n1, guard, last, cnt;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      cfg_we = 1'b0; cfg_coef_a = '0; cfg_coef_b = '0;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      out_ready = 1'b1;

      // Reset state, including ready forced low while a request is pending.
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_c", 32'(out_c), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      #10;
      rst = 1'b0;
      req0_valid = 1'b0;

      // Sustained contention: grants alternate 0,1,0,1, four cycles apart.
      exp_q.push_back({1'b0, 9'd17});
      exp_q.push_back({1'b1, 9'd24});
      exp_q.push_back({1'b0, 9'd17});
      exp_q.push_back({1'b1, 9'd24});
      @(posedge clk); #1;
      req0_a = 4'd1; req0_b = 4'd1; req0_valid = 1'b1;
      req1_a = 4'd2; req1_b = 4'd0; req1_valid = 1'b1;
      n0 = 0; n1 = 0; guard = 0; last = -1;
      while ((n0 < 2 || n1 < 2) && guard < 100) begin
         @(negedge clk);
         guard++;
         if (req0_ready || req1_ready) begin
            chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
            chk("grant_order", 32'(req1_ready), 32'((n0 + n1) % 2));
            if (last >= 0) chk("issue_interval", 32'(cyc - last), 32'd4);
            last = cyc;
            if (req0_ready) n0++; else n1++;
         end
      end
      if (guard >= 100) chk("contention_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();

      // Default coefficients, latency and single-cycle out_valid: 12*3+5*4 = 56.
      issue(1'b0, 4'd3, 4'd4, 9'd56, 1'b1);
      @(negedge clk); chk("lat_mul_a", 32'(out_valid), 32'd0);
      @(negedge clk); chk("lat_mul_b", 32'(out_valid), 32'd0);
      @(negedge clk); chk("lat_out", 32'(out_valid), 32'd1);
      @(negedge clk); chk("lat_after", 32'(out_valid), 32'd0);
      wait_idle();

      // Back-pressure: result held for 5 cycles, no grants while in OUT.
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(1'b0, 4'd3, 4'd4, 9'd56, 1'b1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_c", 32'(out_c), 32'd56);
         chk("hold_id", 32'(out_id), 32'd0);
         chk("hold_ready0", 32'(req0_ready), 32'd0);
         chk("hold_ready1", 32'(req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("release_busy", 32'(busy), 32'd0);
      wait_idle();

      // Coefficient write in IDLE: 15*15+15*15 = 450; write during MUL_A ignored.
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_coef_a = 4'd15; cfg_coef_b = 4'd15;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      issue(1'b1, 4'd15, 4'd15, 9'd450, 1'b1);
      cfg_we = 1'b1; cfg_coef_a = 4'd1; cfg_coef_b = 4'd1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      wait_idle();
      issue(1'b0, 4'd1, 4'd1, 9'd30, 1'b1);
      wait_idle();

      // Write and handshake on the same edge: op uses 12/5 -> 56, not 105.
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_coef_a = 4'd12; cfg_coef_b = 4'd5;
      req0_a = 4'd3; req0_b = 4'd4; req0_valid = 1'b1;
      @(negedge clk);
      chk("same_cycle_ready", 32'(req0_ready), 32'd1);
      if (req0_ready) exp_q.push_back({1'b0, 9'd56});
      @(posedge clk); #1;
      cfg_we = 1'b0; req0_valid = 1'b0;
      wait_idle();

      // Reset during MUL_B: op discarded, nothing comes out.
      issue(1'b0, 4'd3, 4'd4, 9'd0, 1'b0);
      @(posedge clk); #1;
      chk("abort_in_mul_b", 32'(dbg_state), 32'(ST_MUL_B));
      rst = 1'b1;
      req0_valid = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready0", 32'(req0_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_output", 32'(out_valid), 32'd0);
      end

      // Reset restores coefficients: program 15/15, reset, then 12*2+5*2 = 34.
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_coef_a = 4'd15; cfg_coef_b = 4'd15;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      issue(1'b0, 4'd2, 4'd2, 9'd34, 1'b1);
      wait_idle();

      // Back-to-back single requester: ready exactly once per 4 cycles.
      @(posedge clk); #1;
      req0_a = 4'd1; req0_b = 4'd1; req0_valid = 1'b1;
      cnt = 0; last = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req0_ready) begin
            exp_q.push_back({1'b0, 9'd17});
            if (last >= 0) chk("stream_interval", 32'(cyc - last), 32'd4);
            last = cyc;
            cnt++;
         end
      end
      chk("stream_grants", 32'(cnt), 32'd3);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_idle();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_lincomb_sched
